color_match_engine: RTL and testbench
=====================================

Name: color_match_engine

Overview:
- Parametrised successor to the single-target color FSM: a complete multi-round color-matching game engine.
- Integrates a configurable LFSR target generator, an input hold-filter for the color sensor code, a per-round timeout, hit/miss buzzer pulses, a saturating score, and a best-score register.
- Emits 3-bit message codes for the LCD1604 controller.
- Sits between the color sensor decoder and the LCD/buzzer outputs in the top level.

Parameters:
- COLOR_W, 3, width of color codes; code 0 means "no color".
- N_COLORS, 6, number of valid colors, codes 1..N_COLORS; must satisfy N_COLORS <= 2^COLOR_W - 1.
- LFSR_W, 8, LFSR width.
- TAPS, 8'hB8, LFSR feedback mask, LFSR_W bits wide.
- SEED, 8'hA5, LFSR reset value; must be nonzero.
- HOLD_CYC, 2, consecutive identical nonzero samples needed to accept a color.
- TIMEOUT_CYC, 50, WAIT cycles before a round is a miss.
- BUZZ_HIT, 10, buzzer-high cycles on a hit.
- BUZZ_MISS, 50, buzzer-high cycles on a miss.
- ROUNDS, 10, rounds per game.
- SCORE_W, 8, score width.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; starts or restarts a game from IDLE or OVER.
- color  in  COLOR_W  sensor color code; synchronous to clk.
- target  out  COLOR_W  current target color.
- msg  out  3  LCD message code: 0 blank, 1 press start, 2 show target, 3 hit, 4 miss, 5 game over, 6 new record.
- msg_valid  out  1  one-cycle pulse whenever msg changes.
- score  out  SCORE_W  current game score.
- best_score  out  SCORE_W  highest completed-game score since reset.
- buzzer  out  1  buzzer drive.
- busy  out  1  high in NEW_TARGET, WAIT, HIT, MISS.
- done  out  1  high in OVER.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, lfsr=SEED.
  - target, score, best_score, round, timer, hold count all 0.
  - buzzer=0, busy=0, done=0.
  - msg=1, msg_valid=0.
- LFSR:
  - Advances every cycle in all states: fb = ^(lfsr & TAPS); lfsr <= {lfsr[LFSR_W-2:0], fb}.
  - Candidate target = (lfsr % N_COLORS) + 1, using the lfsr value registered before the update.
- Hold filter, active only in WAIT while armed:
  - Same nonzero color on consecutive cycles increments the hold count; any change reloads it to 1, or to 0 when color=0.
  - A color is accepted on the cycle the count reaches HOLD_CYC.
- Armed flag:
  - Cleared on entry to WAIT; set on the first WAIT cycle with color==0.
  - Prevents a color held over from the previous round from being scored.
- IDLE: msg=1. start=1 moves to NEW_TARGET next cycle and sets score=0, round=0.
- NEW_TARGET, exactly 1 cycle: latch target from the candidate, timer=TIMEOUT_CYC, msg=2, then WAIT.
- WAIT:
  - timer decrements every cycle.
  - Accepted color equal to target: go to HIT and score += 1, saturating at 2^SCORE_W-1.
  - Accepted color not equal to target: go to MISS.
  - Timer reaching 0 with no accept: go to MISS after exactly TIMEOUT_CYC WAIT cycles.
  - Accept and timeout on the same cycle: accept wins.
- HIT: msg=3, buzzer=1 for BUZZ_HIT cycles. MISS: msg=4, buzzer=1 for BUZZ_MISS cycles.
- End of HIT/MISS: round += 1. If round == ROUNDS go to OVER, otherwise NEW_TARGET.
- OVER entry:
  - If score > best_score: best_score <= score and msg=6.
  - Otherwise msg=5.
  - done=1. start=1 restarts as from IDLE, with best_score retained.
- start is ignored while busy.
- msg_valid: registered; asserts the cycle after msg changes, one cycle wide.
- Asserting reset mid-round aborts immediately: buzzer drops to 0 asynchronously and the game state is lost.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release -> msg=1, score=0, best_score=0, buzzer=0, busy=0, lfsr=8'hA5; no msg_valid pulse.
- Correct hit: start pulse, then drive color=0 for 1 cycle, then color=target for 2 cycles -> HIT entered on the 2nd matching cycle, score=1, buzzer high exactly 10 cycles, msg sequence 2,3 each with a one-cycle msg_valid.
- Timeout: start, hold color=0 -> MISS exactly 50 cycles after WAIT entry, buzzer high 50 cycles, score unchanged at 0.
- Glitch rejection: in WAIT, color alternates target/0 every cycle for 20 cycles -> no accept, timer keeps running; wrong color held 2 cycles -> MISS.
- Carry-over guard: hold color=target continuously across HIT into the next WAIT -> no second hit until color returns to 0 and is re-held.
- Full game and record: play 10 rounds with 7 hits -> OVER, msg=6, best_score=7. Restart with start and score 4 -> msg=5, best_score stays 7. Assert reset during a BUZZ_MISS buzz -> buzzer=0 immediately.

Source files
------------

// File: rtl/color_match_engine.sv
// Multi-round colour-matching game engine: LFSR target picker, sensor hold filter,
// per-round timeout, buzzer pulses, saturating score and best-score tracking.
module color_match_engine #(
  parameter int unsigned       COLOR_W     = 3,
  parameter int unsigned       N_COLORS    = 6,
  parameter int unsigned       LFSR_W      = 8,
  parameter logic [LFSR_W-1:0] TAPS        = 8'hB8,
  parameter logic [LFSR_W-1:0] SEED        = 8'hA5,
  parameter int unsigned       HOLD_CYC    = 2,
  parameter int unsigned       TIMEOUT_CYC = 50,
  parameter int unsigned       BUZZ_HIT    = 10,
  parameter int unsigned       BUZZ_MISS   = 50,
  parameter int unsigned       ROUNDS      = 10,
  parameter int unsigned       SCORE_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [COLOR_W-1:0] color,
  output logic [COLOR_W-1:0] target,
  output logic [2:0]         msg,
  output logic               msg_valid,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] best_score,
  output logic               buzzer,
  output logic               busy,
  output logic               done
);

  localparam int unsigned TimerW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned HoldW   = $clog2(HOLD_CYC + 1);
  localparam int unsigned BuzzMax = (BUZZ_HIT > BUZZ_MISS) ? BUZZ_HIT : BUZZ_MISS;
  localparam int unsigned BuzzW   = $clog2(BuzzMax + 1);
  localparam int unsigned RoundW  = $clog2(ROUNDS + 1);

  localparam logic [2:0] MsgStart  = 3'd1;
  localparam logic [2:0] MsgTarget = 3'd2;
  localparam logic [2:0] MsgHit    = 3'd3;
  localparam logic [2:0] MsgMiss   = 3'd4;
  localparam logic [2:0] MsgOver   = 3'd5;
  localparam logic [2:0] MsgRecord = 3'd6;

  typedef enum logic [2:0] {
    StIdle,
    StNewTarget,
    StWait,
    StHit,
    StMiss,
    StOver
  } state_e;

  state_e              state_q, state_d;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic [COLOR_W-1:0]  target_q, target_d;
  logic [COLOR_W-1:0]  prev_q, prev_d;
  logic [SCORE_W-1:0]  score_q, score_d;
  logic [SCORE_W-1:0]  best_q, best_d;
  logic [RoundW-1:0]   round_q, round_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [HoldW-1:0]    hold_q, hold_d;
  logic [BuzzW-1:0]    buzz_cnt_q, buzz_cnt_d;
  logic                armed_q, armed_d;
  logic [2:0]          msg_q, msg_d;
  logic                msg_valid_q, msg_valid_d;
  logic                buzzer_q, buzzer_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [LFSR_W-1:0]   lfsr_mod;
  logic [COLOR_W-1:0]  candidate;
  logic                accept;

  assign lfsr_d    = {lfsr_q[LFSR_W-2:0], ^(lfsr_q & TAPS)};
  assign lfsr_mod  = lfsr_q % LFSR_W'(N_COLORS);
  assign candidate = COLOR_W'(lfsr_mod) + COLOR_W'(1);
  assign prev_d    = color;

  // Hold filter: a colour counts only after HOLD_CYC identical nonzero samples while armed.
  always_comb begin
    hold_d = '0;
    accept = 1'b0;
    if (state_q == StWait && armed_q) begin
      if (color == '0) begin
        hold_d = '0;
      end else if (color == prev_q && hold_q != '0) begin
        hold_d = hold_q + HoldW'(1);
      end else begin
        hold_d = HoldW'(1);
      end
      accept = (hold_d == HoldW'(HOLD_CYC));
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    score_d    = score_q;
    best_d     = best_q;
    round_d    = round_q;
    timer_d    = timer_q;
    buzz_cnt_d = buzz_cnt_q;
    armed_d    = armed_q;
    msg_d      = msg_q;

    case (state_q)
      StIdle, StOver: begin
        if (start) begin
          state_d = StNewTarget;
          score_d = '0;
          round_d = '0;
          msg_d   = MsgTarget;
        end
      end
      StNewTarget: begin
        target_d = candidate;
        timer_d  = TimerW'(TIMEOUT_CYC);
        armed_d  = 1'b0;
        state_d  = StWait;
      end
      StWait: begin
        timer_d = timer_q - TimerW'(1);
        if (!armed_q && color == '0) begin
          armed_d = 1'b1;
        end
        // An accept on the final timer cycle still counts.
        if (accept && color == target_q) begin
          state_d    = StHit;
          msg_d      = MsgHit;
          buzz_cnt_d = BuzzW'(BUZZ_HIT - 1);
          score_d    = (score_q == {SCORE_W{1'b1}}) ? score_q : score_q + SCORE_W'(1);
        end else if (accept || timer_q <= TimerW'(1)) begin
          state_d    = StMiss;
          msg_d      = MsgMiss;
          buzz_cnt_d = BuzzW'(BUZZ_MISS - 1);
        end
      end
      StHit, StMiss: begin
        if (buzz_cnt_q == '0) begin
          round_d = round_q + RoundW'(1);
          if (round_d == RoundW'(ROUNDS)) begin
            state_d = StOver;
            if (score_q > best_q) begin
              best_d = score_q;
              msg_d  = MsgRecord;
            end else begin
              msg_d  = MsgOver;
            end
          end else begin
            state_d = StNewTarget;
            msg_d   = MsgTarget;
          end
        end else begin
          buzz_cnt_d = buzz_cnt_q - BuzzW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    msg_valid_d = (msg_d != msg_q);
    buzzer_d    = (state_d == StHit) || (state_d == StMiss);
    busy_d      = (state_d == StNewTarget) || (state_d == StWait) ||
                  (state_d == StHit) || (state_d == StMiss);
    done_d      = (state_d == StOver);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      lfsr_q      <= SEED;
      target_q    <= '0;
      prev_q      <= '0;
      score_q     <= '0;
      best_q      <= '0;
      round_q     <= '0;
      timer_q     <= '0;
      hold_q      <= '0;
      buzz_cnt_q  <= '0;
      armed_q     <= 1'b0;
      msg_q       <= MsgStart;
      msg_valid_q <= 1'b0;
      buzzer_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      target_q    <= target_d;
      prev_q      <= prev_d;
      score_q     <= score_d;
      best_q      <= best_d;
      round_q     <= round_d;
      timer_q     <= timer_d;
      hold_q      <= hold_d;
      buzz_cnt_q  <= buzz_cnt_d;
      armed_q     <= armed_d;
      msg_q       <= msg_d;
      msg_valid_q <= msg_valid_d;
      buzzer_q    <= buzzer_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign target     = target_q;
  assign msg        = msg_q;
  assign msg_valid  = msg_valid_q;
  assign score      = score_q;
  assign best_score = best_q;
  assign buzzer     = buzzer_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_color_match_engine.sv
// Bench for color_match_engine: scripted and random rounds scored against a
// sequence-level model of the hold filter, timeout and game bookkeeping.
module tb_color_match_engine;

  localparam int unsigned NColors  = 6;
  localparam int unsigned Timeout  = 50;
  localparam int unsigned Hold     = 2;
  localparam int unsigned BuzzHit  = 10;
  localparam int unsigned BuzzMiss = 50;
  localparam int unsigned Rounds   = 10;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [2:0] color = 3'd0;
  logic [2:0] target;
  logic [2:0] msg;
  logic       msg_valid;
  logic [7:0] score;
  logic [7:0] best_score;
  logic       buzzer;
  logic       busy;
  logic       done;

  always #5 clk = ~clk;

  color_match_engine #(
    .COLOR_W     (3),
    .N_COLORS    (NColors),
    .LFSR_W      (8),
    .TAPS        (8'hB8),
    .SEED        (8'hA5),
    .HOLD_CYC    (Hold),
    .TIMEOUT_CYC (Timeout),
    .BUZZ_HIT    (BuzzHit),
    .BUZZ_MISS   (BuzzMiss),
    .ROUNDS      (Rounds),
    .SCORE_W     (8)
  ) u_dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .color      (color),
    .target     (target),
    .msg        (msg),
    .msg_valid  (msg_valid),
    .score      (score),
    .best_score (best_score),
    .buzzer     (buzzer),
    .busy       (busy),
    .done       (done)
  );

  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_mv     = 0;
  int         rounds_done;
  int         exp_score;
  int         exp_best = 0;
  logic [2:0] exp_target;
  logic [2:0] last_color = 3'd0;
  bit         rand_start = 1'b0;
  logic [2:0] seq [Timeout];
  logic [7:0] lfsr_m;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & 8'hB8)};
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) lfsr_m <= 8'hA5;
    else        lfsr_m <= lfsr_next(lfsr_m);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (msg_valid) n_mv++;
  endtask

  // Scan the WAIT-phase colour sequence: index of the deciding cycle and whether it is a hit.
  function automatic void predict(input logic [2:0] t, output int k_out, output bit hit);
    bit         armed = 1'b0;
    int         run   = 0;
    logic [2:0] prev  = 3'd0;
    k_out = Timeout - 1;
    hit   = 1'b0;
    for (int k = 0; k < Timeout; k++) begin
      logic [2:0] c = seq[k];
      if (!armed) begin
        if (c == 3'd0) armed = 1'b1;
        run = 0;
      end else if (c == 3'd0) begin
        run = 0;
      end else if (c == prev && run > 0) begin
        run++;
      end else begin
        run = 1;
      end
      if (armed && run == Hold) begin
        k_out = k;
        hit   = (c == t);
        return;
      end
      prev = c;
    end
  endfunction

  task automatic gen_seq(input int mode);
    logic [2:0] w;
    logic [2:0] c = 3'd0;
    int         a;
    do w = 3'($urandom_range(1, NColors)); while (w == exp_target);
    for (int k = 0; k < Timeout; k++) seq[k] = 3'd0;
    case (mode)
      0: begin
        a = $urandom_range(1, 3);
        seq[a] = exp_target;
        seq[a+1] = exp_target;
      end
      1: begin
        seq[1] = w;
        seq[2] = w;
      end
      3: begin
        for (int k = 1; k <= 20; k++) seq[k] = (k % 2 == 1) ? exp_target : 3'd0;
        seq[21] = w;
        seq[22] = w;
      end
      4: begin
        for (int k = 0; k < 5; k++) seq[k] = last_color;
        seq[6] = exp_target;
        seq[7] = exp_target;
      end
      5: begin
        for (int k = 0; k < Timeout; k++) begin
          case ($urandom_range(0, 3))
            0: c = 3'd0;
            1: c = exp_target;
            2: c = 3'($urandom_range(0, 7));
            default: ;
          endcase
          seq[k] = c;
        end
      end
      6: begin
        seq[Timeout-2] = exp_target;
        seq[Timeout-1] = exp_target;
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    check_eq("rst_msg", msg, 1);
    check_eq("rst_mv", msg_valid, 0);
    check_eq("rst_score", score, 0);
    check_eq("rst_best", best_score, 0);
    check_eq("rst_buzzer", buzzer, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_target", target, 0);
    n_mv = 0;
    tick();
    tick();
    check_eq("idle_msg", msg, 1);
    check_eq("idle_no_mv", n_mv, 0);
  endtask

  task automatic start_game();
    start = 1'b1;
    n_mv = 0;
    rounds_done = 0;
    exp_score = 0;
    tick();
    start = 1'b0;
    check_eq("start_msg", msg, 2);
    check_eq("start_mv", msg_valid, 1);
    check_eq("start_busy", busy, 1);
    check_eq("start_done", done, 0);
    check_eq("start_score", score, 0);
    exp_target = 3'(lfsr_m % NColors) + 3'd1;
  endtask

  task automatic play_round(input int mode, input bit abort);
    int k;
    int n;
    int k_exp;
    bit hit;
    gen_seq(mode);
    predict(exp_target, k_exp, hit);
    tick();
    check_eq("target", target, exp_target);
    check_eq("wait_msg", msg, 2);
    check_eq("wait_mv", msg_valid, 0);
    k = 0;
    while (msg == 3'd2 && k < Timeout + 5) begin
      color = (k < Timeout) ? seq[k] : 3'd0;
      if (rand_start) start = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    start = 1'b0;
    check_eq("wait_len", k, k_exp + 1);
    check_eq("outcome", msg, hit ? 3 : 4);
    check_eq("outcome_mv", msg_valid, 1);
    if (hit && exp_score < 255) exp_score++;
    check_eq("score", score, exp_score);
    last_color = color;
    n = 0;
    while (buzzer && n < 120) begin
      if (abort && n == 20) begin
        #2;
        reset = 1'b0;
        #1;
        check_eq("abort_buzzer", buzzer, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_msg", msg, 1);
        return;
      end
      n++;
      tick();
    end
    check_eq("buzz_len", n, hit ? BuzzHit : BuzzMiss);
    rounds_done++;
    if (rounds_done == Rounds) begin
      if (exp_score > exp_best) begin
        exp_best = exp_score;
        check_eq("over_msg", msg, 6);
      end else begin
        check_eq("over_msg", msg, 5);
      end
      check_eq("over_mv", msg_valid, 1);
      check_eq("over_done", done, 1);
      check_eq("over_busy", busy, 0);
      check_eq("over_best", best_score, exp_best);
      check_eq("game_mv_pulses", n_mv, 1 + 2 * Rounds);
    end else begin
      check_eq("next_msg", msg, 2);
      check_eq("next_mv", msg_valid, 1);
      exp_target = 3'(lfsr_m % NColors) + 3'd1;
    end
  endtask

  int g1 [Rounds] = '{0, 1, 0, 2, 0, 4, 3, 0, 0, 0};
  int g2 [Rounds] = '{0, 6, 0, 0, 1, 1, 2, 1, 3, 1};

  initial begin
    #2;
    do_reset();

    start_game();
    for (int r = 0; r < Rounds; r++) play_round(g1[r], 1'b0);
    check_eq("g1_score", score, 7);
    check_eq("g1_best", best_score, 7);
    tick();
    check_eq("g1_hold_over", done, 1);

    start_game();
    for (int r = 0; r < Rounds; r++) play_round(g2[r], 1'b0);
    check_eq("g2_score", score, 4);
    check_eq("g2_best", best_score, 7);

    rand_start = 1'b1;
    start_game();
    for (int r = 0; r < Rounds; r++) play_round($urandom_range(0, 6), 1'b0);
    rand_start = 1'b0;

    start_game();
    play_round(2, 1'b1);
    exp_best = 0;
    do_reset();
    start_game();
    play_round(0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
